// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// PREADY wait states with optional timeout abort, and a registered response.
//
// Ports:
//   PCLK, PRESET                 clock, asynchronous active-high reset
//   reqN_valid/write/addr/wdata  requester N transfer request (N = 0, 1)
//   reqN_done                    one-cycle completion pulse to requester N
//   rsp_rdata, rsp_err           response of the last completed transfer
//   grant, busy                  current bus owner; high in SETUP/ACCESS
//   PSEL..PWDATA, PRDATA..       APB master interface
module apb_master_arb #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              grant,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Last wait-counter value before abort; unused when TIMEOUT is 0.
  localparam logic [7:0] TLIM =
    (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t            state, state_n;
  logic              last_grant, last_grant_n;
  logic [7:0]        wcnt, wcnt_n;
  logic              psel_n, penable_n, pwrite_n;
  logic [AWIDTH-1:0] paddr_n;
  logic [DWIDTH-1:0] pwdata_n, rdata_n;
  logic              done0_n, done1_n, err_n, grant_n;
  logic              el0, el1, win, finish;

  // A requester whose done is high has not yet seen its completion;
  // masking it lets the other side win and enforces alternation.
  assign el0 = req0_valid & ~req0_done;
  assign el1 = req1_valid & ~req1_done;
  assign win = (el0 & el1) ? ~last_grant : el1;

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    wcnt_n       = wcnt;
    psel_n       = PSEL;
    penable_n    = PENABLE;
    pwrite_n     = PWRITE;
    paddr_n      = PADDR;
    pwdata_n     = PWDATA;
    rdata_n      = rsp_rdata;
    err_n        = rsp_err;
    grant_n      = grant;
    done0_n      = 1'b0;
    done1_n      = 1'b0;
    finish       = 1'b0;
    unique case (state)
      IDLE: begin
        psel_n = 1'b0;
        if (el0 | el1) begin
          pwrite_n  = win ? req1_write : req0_write;
          paddr_n   = win ? req1_addr  : req0_addr;
          pwdata_n  = win ? req1_wdata : req0_wdata;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          grant_n   = win;
          state_n   = SETUP;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        wcnt_n    = 8'd0;
        state_n   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          err_n = PSLVERR;
          if (!PWRITE) rdata_n = PRDATA;
          finish = 1'b1;
        end else begin
          wcnt_n = wcnt + 8'd1;
          if (TIMEOUT != 0 && wcnt == TLIM) begin
            err_n  = 1'b1;
            finish = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (finish) begin
      done0_n      = ~grant;
      done1_n      = grant;
      last_grant_n = grant;
      psel_n       = 1'b0;
      penable_n    = 1'b0;
      state_n      = IDLE;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wcnt       <= 8'd0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      grant      <= 1'b0;
      busy       <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      wcnt       <= wcnt_n;
      PSEL       <= psel_n;
      PENABLE    <= penable_n;
      PWRITE     <= pwrite_n;
      PADDR      <= paddr_n;
      PWDATA     <= pwdata_n;
      rsp_rdata  <= rdata_n;
      rsp_err    <= err_n;
      grant      <= grant_n;
      busy       <= (state_n != IDLE);
      req0_done  <= done0_n;
      req1_done  <= done1_n;
    end
  end

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Two-requester APB master that sequences accesses to the APB register slave (the address decoder and register bank) on a shared bus.
- Arbitrates round-robin between requester 0 and requester 1.
- Drives the APB SETUP and ACCESS phases, honours PREADY wait states and aborts a hung transfer after a timeout.
- Returns read data, error status and a one-cycle done pulse to the granted requester.

Parameters:
- AWIDTH, 4, APB address width.
- DWIDTH, 8, APB data width.
- TIMEOUT, 15, maximum PREADY-low cycles in ACCESS before abort; 0 disables the timeout; legal range 0..255.

Ports:
- PCLK  input  1  bus clock; all state updates on its rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a pending transfer.
- req0_write  input  1  requester 0 direction: 1 = write, 0 = read.
- req0_addr  input  AWIDTH  requester 0 address.
- req0_wdata  input  DWIDTH  requester 0 write data.
- req0_done  output  1  one-cycle completion pulse to requester 0.
- req1_valid, req1_write, req1_addr, req1_wdata  input  1/1/AWIDTH/DWIDTH  same meaning for requester 1.
- req1_done  output  1  one-cycle completion pulse to requester 1.
- rsp_rdata  output  DWIDTH  read data of the last completed read.
- rsp_err  output  1  error status of the last completed transfer.
- grant  output  1  requester currently owning the bus; valid while busy.
- busy  output  1  high in SETUP and ACCESS.
- PSEL, PENABLE, PWRITE  output  1 each  APB control.
- PADDR  output  AWIDTH  APB address.
- PWDATA  output  DWIDTH  APB write data.
- PRDATA  input  DWIDTH  APB read data.
- PREADY  input  1  slave ready.
- PSLVERR  input  1  slave error.

Behaviour:
- Reset values (applied immediately on PRESET, whatever the state):
  - state = IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0.
  - req0_done, req1_done = 0; rsp_rdata = 0; rsp_err = 0.
  - grant = 0; busy = 0; wait counter = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- Reset mid-transfer: the transfer is dropped and no done pulse is issued.
- FSM states: IDLE, SETUP, ACCESS. busy = (state != IDLE). All outputs are registered.
- IDLE, arbitration:
  - A requester is eligible if its valid is high and its done output is low in that cycle. This masks a requester that has not yet dropped valid after completion.
  - One eligible requester: it wins.
  - Both eligible: the requester != last_grant wins.
  - On a win: capture write/addr/wdata into PWRITE/PADDR/PWDATA; set PSEL = 1, PENABLE = 0, grant = winner; go to SETUP.
  - No eligible requester: stay in IDLE with PSEL = 0.
- SETUP: lasts exactly one cycle. Set PENABLE = 1, clear the wait counter, go to ACCESS.
- ACCESS with PREADY = 1:
  - rsp_err <= PSLVERR.
  - If PWRITE = 0: rsp_rdata <= PRDATA. If PWRITE = 1: rsp_rdata holds its value.
  - Pulse done of grant for exactly one cycle.
  - last_grant <= grant; PSEL = PENABLE = 0; go to IDLE.
- ACCESS with PREADY = 0:
  - Increment the wait counter.
  - If TIMEOUT != 0 and counter == TIMEOUT - 1: abort. rsp_err <= 1, rsp_rdata unchanged, done pulse, last_grant update, PSEL = PENABLE = 0, go to IDLE.
- Latency with zero wait states:
  - valid is sampled high in IDLE at edge N.
  - SETUP is visible in cycle N+1 and ACCESS in cycle N+2.
  - done is high in cycle N+3, which is an IDLE cycle.
  - With TIMEOUT = 0 there is no abort; the FSM waits indefinitely.
- Back-to-back transfers: at least one IDLE cycle separates transfers (the cycle in which done is high). A requester holding valid continuously alternates with the other requester whenever both are pending.
- Requester rules:
  - valid, write, addr and wdata must be held stable until done.
  - Changes after capture are ignored.
  - Dropping valid before done does not cancel the transfer.
- rsp_rdata and rsp_err are valid in the done cycle and hold until the next completion.
- No address checking is done here; address range errors come from the slave via PSLVERR.

Test Plan:
- Single write, zero wait: req0 write addr=2 wdata=0xA5, PREADY=1. Then: SETUP with PSEL=1 PENABLE=0 PADDR=2 PWDATA=0xA5, then ACCESS with PENABLE=1. req0_done is high for 1 cycle 3 cycles after the sample; rsp_err=0.
- Read with 2 wait states: req1 read addr=6, PREADY low for 2 ACCESS cycles, then high with PRDATA=0x3C. Then: req1_done once, rsp_rdata=0x3C, rsp_err=0, grant=1 during busy.
- Contention: both valid continuously from reset. Grants go 0,1,0,1 over 4 transfers with exactly one IDLE cycle between them; no done is ever issued to the wrong requester.
- Slave error: read addr=7 with PSLVERR=1 and PREADY=1. Then: rsp_err=1, rsp_rdata=PRDATA, single done pulse.
- Timeout: TIMEOUT=4, PREADY held 0. Abort after 4 ACCESS cycles with rsp_err=1; rsp_rdata unchanged; PSEL=0 in the next cycle.
- Reset mid-ACCESS: assert PRESET while PENABLE=1. All outputs go to 0 asynchronously with no done pulse. After release, the first contention is granted to requester 0.
